// File: rtl/sobel_pixel_feeder_if.sv
// Pixel-in / beat-out bus of the Sobel pixel feeder.
// master: the environment (pixel source and beat sink); slave: the feeder.
interface sobel_pixel_feeder_if;
    logic [7:0]  in_pixel;
    logic        in_valid;
    logic        in_sof;
    logic        in_ready;
    logic [31:0] out_dataa;
    logic [31:0] out_datab;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_col;
    logic [6:0]  out_row;
    logic        out_sol;
    logic        out_eol;
    logic        out_eof;
    logic        frame_done;
    logic        err_sof;

    modport master (
        output in_pixel, in_valid, in_sof, out_ready,
        input  in_ready, out_dataa, out_datab, out_valid, out_col, out_row,
               out_sol, out_eol, out_eof, frame_done, err_sof
    );

    modport slave (
        input  in_pixel, in_valid, in_sof, out_ready,
        output in_ready, out_dataa, out_datab, out_valid, out_col, out_row,
               out_sol, out_eol, out_eof, frame_done, err_sof
    );
endinterface

// File: rtl/sobel_pixel_feeder.sv
// Packs a raster 8-bit pixel stream into 8-pixel beats (two 32-bit words)
// with column/row/line/frame sidebands for the Sobel stage.
module sobel_pixel_feeder #(
    parameter int unsigned LINE_WIDTH  = 64,
    parameter int unsigned FRAME_LINES = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    sobel_pixel_feeder_if.slave  bus
);

    localparam int unsigned PIX_W = 8;
    localparam int unsigned ACC_W = 64;
    localparam int unsigned LANE_W = 3;
    localparam int unsigned POS_W = 7;
    localparam int unsigned WORD_W = 32;
    localparam logic [POS_W-1:0] COL_STEP = POS_W'(8);
    localparam logic [POS_W-1:0] LAST_COL = POS_W'(LINE_WIDTH - 8);
    localparam logic [POS_W-1:0] LAST_ROW = POS_W'(FRAME_LINES - 1);

    typedef enum logic {
        WAIT_SOF,
        ACTIVE
    } state_t;

    state_t              state_q, state_d;

    // Accumulator: pixels of the beat being assembled plus its position.
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic                full_q, full_d;
    logic [POS_W-1:0]    col_q, col_d;
    logic [POS_W-1:0]    row_q, row_d;

    // Output register.
    logic [WORD_W-1:0]   dataa_q, datab_q;
    logic                out_valid_q;
    logic [POS_W-1:0]    out_col_q, out_row_q;
    logic                sol_q, eol_q, eof_q;
    logic                frame_done_q;
    logic                err_sof_q;

    // Next-state helpers.
    logic [POS_W-1:0]    adv_col, adv_row;
    logic [LANE_W-1:0]   lane_w;
    logic                out_free;
    logic                accept;
    logic                load_out;
    logic [ACC_W-1:0]    load_data;
    logic [POS_W-1:0]    load_col, load_row;
    logic                err_d;

    // Output register can take a beat when it is empty or being drained.
    assign out_free = !out_valid_q || bus.out_ready;

    // Stall only while a completed beat is stuck in the accumulator.
    assign bus.in_ready = reset && (!full_q || out_free);
    assign accept       = bus.in_valid && bus.in_ready;

    // Position of the beat following the one currently in the accumulator.
    always_comb begin
        adv_col = col_q + COL_STEP;
        adv_row = row_q;
        if (col_q == LAST_COL) begin
            adv_col = '0;
            adv_row = (row_q == LAST_ROW) ? '0 : row_q + POS_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= WAIT_SOF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, accumulator update and beat transfer decision.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        lane_d    = lane_q;
        full_d    = full_q;
        col_d     = col_q;
        row_d     = row_q;
        load_out  = 1'b0;
        load_data = acc_q;
        load_col  = col_q;
        load_row  = row_q;
        err_d     = 1'b0;
        // A full accumulator always restarts at lane 0 once drained.
        lane_w    = full_q ? '0 : lane_q;

        // Drain a completed beat waiting in the accumulator.
        if (full_q && out_free) begin
            load_out = 1'b1;
            full_d   = 1'b0;
            lane_d   = '0;
            col_d    = adv_col;
            row_d    = adv_row;
        end

        if (accept) begin
            if (bus.in_sof) begin
                // Start of frame, expected or not: restart at lane 0, (0,0).
                acc_d   = ACC_W'(bus.in_pixel);
                lane_d  = LANE_W'(1);
                col_d   = '0;
                row_d   = '0;
                state_d = ACTIVE;
                err_d   = (state_q == ACTIVE);
            end else if (state_q == ACTIVE) begin
                acc_d[{lane_w, 3'b000} +: PIX_W] = bus.in_pixel;
                lane_d = lane_w + LANE_W'(1);
                if (lane_w == LANE_W'(7)) begin
                    if (col_q == LAST_COL && row_q == LAST_ROW) begin
                        state_d = WAIT_SOF;
                    end
                    // Completing pixel goes straight out when possible.
                    if (out_free) begin
                        load_out  = 1'b1;
                        load_data = acc_d;
                        col_d     = adv_col;
                        row_d     = adv_row;
                    end else begin
                        full_d = 1'b1;
                    end
                end
            end
        end
    end

    // Accumulator and position registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            lane_q <= '0;
            full_q <= 1'b0;
            col_q  <= '0;
            row_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            lane_q <= lane_d;
            full_q <= full_d;
            col_q  <= col_d;
            row_q  <= row_d;
        end
    end

    // Output register: load a beat, clear valid on drain, hold otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dataa_q     <= '0;
            datab_q     <= '0;
            out_valid_q <= 1'b0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            sol_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else if (load_out) begin
            dataa_q     <= load_data[WORD_W-1:0];
            datab_q     <= load_data[ACC_W-1:WORD_W];
            out_valid_q <= 1'b1;
            out_col_q   <= load_col;
            out_row_q   <= load_row;
            sol_q       <= (load_col == '0);
            eol_q       <= (load_col == LAST_COL);
            eof_q       <= (load_col == LAST_COL) && (load_row == LAST_ROW);
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // One-cycle status pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_done_q <= 1'b0;
            err_sof_q    <= 1'b0;
        end else begin
            frame_done_q <= out_valid_q && bus.out_ready && eof_q;
            err_sof_q    <= err_d;
        end
    end

    assign bus.out_dataa  = dataa_q;
    assign bus.out_datab  = datab_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_col    = out_col_q;
    assign bus.out_row    = out_row_q;
    assign bus.out_sol    = sol_q;
    assign bus.out_eol    = eol_q;
    assign bus.out_eof    = eof_q;
    assign bus.frame_done = frame_done_q;
    assign bus.err_sof    = err_sof_q;

endmodule

// File: tb/tb_sobel_pixel_feeder.sv
// Directed self-checking bench for sobel_pixel_feeder (64x64 frame).
module tb_sobel_pixel_feeder;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    sobel_pixel_feeder_if bus();

    sobel_pixel_feeder #(
        .LINE_WIDTH  (64),
        .FRAME_LINES (64)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int beats;
    int stalls;
    int eof_cnt;
    logic exp_fd;
    logic [31:0] exp_a;
    logic [31:0] exp_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] p);
        bus.in_valid = v;
        bus.in_sof   = s;
        bus.in_pixel = p;
    endtask

    function automatic logic [7:0] frame_pix(input int i);
        return 8'((i * 7) ^ (i >> 6));
    endfunction

    initial begin
        drive(1'b0, 1'b0, 8'h00);
        bus.out_ready = 1'b0;

        // Reset state
        #1 reset = 1'b0;
        #2;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_data", {bus.out_dataa, bus.out_datab}, 0);
        check("rst_pos", {bus.out_col, bus.out_row}, 0);
        check("rst_flags", {bus.out_sol, bus.out_eol, bus.out_eof, bus.frame_done, bus.err_sof}, 0);
        #14 reset = 1'b1;
        #1;
        check("in_ready_after_release", bus.in_ready, 1);
        step();

        // Pre-sof garbage
        bus.out_ready = 1'b1;
        beats = 0;
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 8'(8'h40 + i));
            #1;
            if (!bus.in_ready) stalls++;
            step();
            if (bus.out_valid) beats++;
        end
        check("presof_beats", beats, 0);
        check("presof_stalls", stalls, 0);

        // Single beat
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, 8'(i + 1));
            step();
            if (i == 6) check("single_early_valid", bus.out_valid, 0);
        end
        drive(1'b0, 1'b0, 8'h00);
        check("single_valid", bus.out_valid, 1);
        check("single_dataa", bus.out_dataa, 32'h04030201);
        check("single_datab", bus.out_datab, 32'h08070605);
        check("single_col", bus.out_col, 0);
        check("single_row", bus.out_row, 0);
        check("single_sol", bus.out_sol, 1);
        check("single_eol", bus.out_eol, 0);
        check("single_err_sof", bus.err_sof, 0);
        step();
        check("single_valid_one_cycle", bus.out_valid, 0);

        // Backpressure: beats at col 8 and col 16 of row 0
        bus.out_ready = 1'b0;
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'(8'h10 + i));
            #1;
            if (!bus.in_ready) stalls++;
            step();
            if (i == 8) check("bp_beat1_held_early", bus.out_dataa, 32'h13121110);
        end
        drive(1'b0, 1'b0, 8'h00);
        #1;
        check("bp_accept_stalls", stalls, 0);
        check("bp_in_ready_low", bus.in_ready, 0);
        check("bp_beat1_valid", bus.out_valid, 1);
        check("bp_beat1_dataa", bus.out_dataa, 32'h13121110);
        check("bp_beat1_datab", bus.out_datab, 32'h17161514);
        check("bp_beat1_col", bus.out_col, 8);
        bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready_back", bus.in_ready, 1);
        step();
        check("bp_beat2_valid", bus.out_valid, 1);
        check("bp_beat2_dataa", bus.out_dataa, 32'h1B1A1918);
        check("bp_beat2_datab", bus.out_datab, 32'h1F1E1D1C);
        check("bp_beat2_col", bus.out_col, 16);
        check("bp_beat2_sol", bus.out_sol, 0);
        step();
        check("bp_drained", bus.out_valid, 0);

        // Unexpected sof after 3 pixels at col 24
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'(8'h31 + i));
            step();
        end
        check("usof_no_err_yet", bus.err_sof, 0);
        drive(1'b1, 1'b1, 8'hAA);
        step();
        check("usof_err_pulse", bus.err_sof, 1);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, 8'(8'hB1 + i));
            step();
            if (i == 0) check("usof_err_one_cycle", bus.err_sof, 0);
        end
        drive(1'b0, 1'b0, 8'h00);
        check("usof_valid", bus.out_valid, 1);
        check("usof_dataa", bus.out_dataa, 32'hB3B2B1AA);
        check("usof_datab", bus.out_datab, 32'hB7B6B5B4);
        check("usof_pos", {bus.out_col, bus.out_row}, 0);
        step();

        // Reset with a pending beat and 5 partial pixels
        bus.out_ready = 1'b0;
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, 1'b0, 8'(8'h50 + i));
            step();
        end
        drive(1'b0, 1'b0, 8'h00);
        check("rmid_pending", bus.out_valid, 1);
        #1 reset = 1'b0;
        #1;
        check("rmid_out_valid", bus.out_valid, 0);
        check("rmid_in_ready", bus.in_ready, 0);
        #2 reset = 1'b1;
        step();
        bus.out_ready = 1'b1;
        beats = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 8'(8'h60 + i));
            step();
            if (bus.out_valid) beats++;
        end
        check("rmid_no_beats_before_sof", beats, 0);

        // Full 64x64 frame, continuous, followed by discarded pixels
        beats = 0;
        stalls = 0;
        eof_cnt = 0;
        exp_fd = 1'b0;
        for (int c = 0; c < 4096 + 20; c++) begin
            if (c < 4096) drive(1'b1, c == 0, frame_pix(c));
            else          drive(1'b1, 1'b0, 8'hEE);
            #1;
            if (!bus.in_ready) stalls++;
            step();
            check("frame_done", bus.frame_done, exp_fd);
            check("frame_err_sof", bus.err_sof, 0);
            exp_fd = 1'b0;
            if (bus.out_valid) begin
                if (beats < 512) begin
                    for (int l = 0; l < 4; l++) begin
                        exp_a[l*8 +: 8] = frame_pix(beats * 8 + l);
                        exp_b[l*8 +: 8] = frame_pix(beats * 8 + 4 + l);
                    end
                    check("frame_dataa", bus.out_dataa, exp_a);
                    check("frame_datab", bus.out_datab, exp_b);
                    check("frame_col", bus.out_col, (beats % 8) * 8);
                    check("frame_row", bus.out_row, beats / 8);
                    check("frame_sol", bus.out_sol, (beats % 8) == 0);
                    check("frame_eol", bus.out_eol, (beats % 8) == 7);
                    check("frame_eof", bus.out_eof, beats == 511);
                end
                if (bus.out_eof) eof_cnt++;
                exp_fd = (beats == 511);
                beats++;
            end
        end
        drive(1'b0, 1'b0, 8'h00);
        check("frame_beats", beats, 512);
        check("frame_eof_count", eof_cnt, 1);
        check("frame_stalls", stalls, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sobel_pixel_feeder.md
# sobel_pixel_feeder

Upstream stage of the Sobel custom-instruction datapath. Accepts a raster-ordered 8-bit grayscale pixel stream with valid/ready handshake, packs eight consecutive pixels into the two 32-bit operand words consumed by the Sobel stage, and presents one beat per handshake together with column/row/line/frame position sidebands. Its `out_valid & out_ready` handshake is the Sobel stage's `clock_en` qualifier.

## Interface
- `LINE_WIDTH`, default 64: pixels per image line. Must be a multiple of 8 and ≤128.
- `FRAME_LINES`, default 64: lines per frame, ≤128.
- `clock`, in, 1: clock, rising edge.
- `reset`, in, 1: reset, asynchronous, active-low.
- `in_pixel`, in, 8: pixel byte.
- `in_valid`, in, 1: `in_pixel` valid.
- `in_sof`, in, 1: the current pixel is the first pixel of a frame.
- `in_ready`, out, 1: pixel is accepted when `in_valid & in_ready`.
- `out_dataa`, out, 32: pixels 0..3 of the beat, pixel 0 in `[7:0]`.
- `out_datab`, out, 32: pixels 4..7 of the beat, pixel 4 in `[7:0]`.
- `out_valid`, out, 1: beat valid.
- `out_ready`, in, 1: downstream accepts the beat.
- `out_col`, out, 7: column of pixel 0 of the beat (multiple of 8).
- `out_row`, out, 7: row of the beat.
- `out_sol`, out, 1: beat starts a line (`out_col == 0`).
- `out_eol`, out, 1: beat ends a line (`out_col == LINE_WIDTH-8`).
- `out_eof`, out, 1: last beat of the frame (`out_eol` and `out_row == FRAME_LINES-1`).
- `frame_done`, out, 1: one-cycle pulse when the `out_eof` beat handshakes.
- `err_sof`, out, 1: one-cycle pulse on an unexpected `in_sof`.

## Operation
- **Structure**
  - Accumulator: 64-bit register, 3-bit lane counter.
  - Output register: data plus sidebands.
  - Column and row counters for the accumulator position.
  - FSM with states WAIT_SOF and ACTIVE.
- **Packing**
  - The k-th accepted pixel of a beat goes to accumulator lane k.
  - Lanes 0–3 map to `out_dataa` bytes 0–3; lanes 4–7 map to `out_datab` bytes 0–3.
- **Transfer**
  - Condition: accumulator holds 8 pixels and (`!out_valid` or `out_ready`).
  - Action: the accumulator and its column/row load into the output register, `out_valid` is set, and the lane counter clears.
  - The transfer can happen in the same cycle as a new pixel accept, which then lands in lane 0.
- **Handshake rules**
  - `out_valid` clears on `out_ready` when no transfer occurs in that cycle.
  - `in_ready` = 0 when the accumulator is full and no transfer occurs in that cycle; otherwise `in_ready` = 1. It is combinational from state and `out_ready`.
  - With `out_ready` held high, throughput is 1 pixel/cycle with no bubbles.
- **State WAIT_SOF**
  - Accepted pixels with `in_sof=0` are discarded.
  - An accepted pixel with `in_sof=1` is written to lane 0 with col=0, row=0, and the FSM moves to ACTIVE.
- **State ACTIVE**
  - Each accepted pixel increments the lane counter.
  - On lane 7: col += 8. At `LINE_WIDTH` the column wraps to 0 and the row increments.
  - When the last pixel of the frame (row `FRAME_LINES-1`, col `LINE_WIDTH-1`) is accepted, the FSM moves to WAIT_SOF. The completed beat still transfers normally.
- **Unexpected `in_sof` in ACTIVE** (accepted pixel that is not frame pixel 0):
  - Pulse `err_sof`.
  - Discard the partial accumulator.
  - Restart the frame with this pixel in lane 0 at col 0, row 0; the FSM stays in ACTIVE.
  - A beat already in the output register is unaffected and still handshakes.
- **Data stability:** `out_*` data and sidebands hold stable while `out_valid & !out_ready`.

## Timing
- **Reset values**
  - All outputs are 0, with one exception: `in_ready` is 0 while reset is asserted and 1 in the first cycle after release (WAIT_SOF, empty accumulator).
  - FSM state is WAIT_SOF; the accumulator and counters are cleared.
- **Latency:** the 8th pixel of a beat accepted at edge n gives `out_valid`=1 after edge n (visible cycle n+1), provided the output register is free or draining.
- `frame_done` and `err_sof` are registered pulses, high for exactly one cycle after the triggering edge.
- **Reset mid-operation**
  - Asynchronous assertion clears everything immediately.
  - The pending beat and partial pixels are lost.
  - The next frame requires `in_sof`.
- **Simultaneous events**
  - `out_ready` with a full accumulator: drain and refill occur in the same edge.
  - `in_sof` on the pixel completing a beat: the sof restart wins and the partial beat is discarded.

## Test plan
- **Single beat:** after reset, drive `in_sof` with pixels 0x01..0x08 back-to-back, `out_ready`=1. Required: `out_dataa`=0x04030201, `out_datab`=0x08070605, `out_valid` for 1 cycle one cycle after the 8th accept, `out_col`=0, `out_row`=0, `out_sol`=1.
- **Backpressure:** `out_ready`=0, stream 16 pixels 0x10..0x1F. Required:
  - beat 1 (0x13121110/0x17161514) is held stable;
  - `in_ready` drops after the 16th accept.
  - After raising `out_ready`: beat 2 (0x1B1A1918/0x1F1E1D1C) follows in the next cycle, and `in_ready` returns to 1.
- **Full 64×64 frame, continuous:**
  - 512 beats; `out_eol` on every 8th beat; row increments 0→63;
  - `out_eof` and `frame_done` only on the beat with col 56, row 63;
  - subsequent pixels without `in_sof` are discarded with no `out_valid`.
- **Unexpected sof:** in ACTIVE, accept 3 pixels, then a pixel 0xAA with `in_sof`. Required: `err_sof` pulses once; the next beat has `out_dataa[7:0]`=0xAA, col 0, row 0.
- **Reset mid-beat:** assert reset after 5 pixels with a beat pending. Required: `out_valid`=0 and `in_ready`=0 immediately; after release, no beat is produced until `in_sof`.
- **Pre-sof garbage:** 20 pixels with `in_sof`=0 after reset produce no beats; `in_ready` stays 1.
